// File: rtl/risk_issue.sv
// risk_issue -- issue stage in front of the risk matrix unit.
//
// Accepts compact matrix instructions over a valid/ready port into a
// DEPTH-entry FIFO, then expands each instruction into count+1 consecutive
// risk ops with an auto-incremented address. A one-cycle NOP bubble is
// inserted between a store and an immediately following load so the risk
// unit's delayed write enable has landed before the load reads.
//
// Optional feature macro: RISK_ISSUE_PERF_EN
//   When defined, adds saturating 16-bit counters perf_issued_o (cycles with
//   a valid op on risk_func_o) and perf_bubbles_o (BUBBLE cycles).
//
// Ports:
//   clk_i            clock, all logic on posedge
//   reset_i          synchronous active-high reset
//   in_valid_i       instruction valid
//   in_ready_o       FIFO not full (combinational)
//   in_func_i        000 load, 001 store, 010 zero, others invalid (issue as NOP)
//   in_reg_i         register index
//   in_addr_i        start address
//   in_addr_inc_i    address increment per repeat
//   in_stride_x_i    x stride, held for all repeats
//   in_stride_y_i    y stride, held for all repeats
//   in_count_i       extra repeats (total ops = count+1)
//   risk_func_o      registered op code, 3'b111 = NOP
//   risk_reg_o       registered register index
//   risk_addr_o      registered address
//   risk_stride_x_o  registered x stride
//   risk_stride_y_o  registered y stride
//   perf_issued_o    (RISK_ISSUE_PERF_EN only) issued-op cycle counter
//   perf_bubbles_o   (RISK_ISSUE_PERF_EN only) bubble cycle counter
//   busy_o           FIFO non-empty, repeats remaining, or bubble pending

module risk_issue #(
    parameter int LOGCNT   = 5,
    parameter int LOGDEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [2:0]             in_func_i,
    input  logic [4:0]             in_reg_i,
    input  logic [10+LOGCNT-1:0]   in_addr_i,
    input  logic [10+LOGCNT-1:0]   in_addr_inc_i,
    input  logic [10+LOGCNT-2:0]   in_stride_x_i,
    input  logic [10+LOGCNT-2:0]   in_stride_y_i,
    input  logic [7:0]             in_count_i,
    output logic [2:0]             risk_func_o,
    output logic [4:0]             risk_reg_o,
    output logic [10+LOGCNT-1:0]   risk_addr_o,
    output logic [10+LOGCNT-2:0]   risk_stride_x_o,
    output logic [10+LOGCNT-2:0]   risk_stride_y_o,
`ifdef RISK_ISSUE_PERF_EN
    output logic [15:0]            perf_issued_o,
    output logic [15:0]            perf_bubbles_o,
`endif
    output logic                   busy_o
);

    localparam int AW    = 10 + LOGCNT;
    localparam int SW    = 10 + LOGCNT - 1;
    localparam int DEPTH = 1 << LOGDEPTH;

    localparam logic [2:0] FUNC_LOAD  = 3'b000;
    localparam logic [2:0] FUNC_STORE = 3'b001;
    localparam logic [2:0] FUNC_ZERO  = 3'b010;
    localparam logic [2:0] FUNC_NOP   = 3'b111;

    typedef struct packed {
        logic [2:0]    func;
        logic [4:0]    rgi;
        logic [AW-1:0] addr;
        logic [AW-1:0] inc;
        logic [SW-1:0] sx;
        logic [SW-1:0] sy;
        logic [7:0]    cnt;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    instr_t                fifo_mem_q [DEPTH];
    logic [LOGDEPTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LOGDEPTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LOGDEPTH:0]     occ_q, occ_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    instr_t                head;
    instr_t                in_instr;

    assign fifo_full  = (occ_q == (LOGDEPTH+1)'(DEPTH));
    assign fifo_empty = (occ_q == '0);
    // Ready depends only on the registered occupancy: a pop in the same
    // cycle does not open the door until the next cycle.
    assign in_ready_o = !fifo_full;
    assign push       = in_valid_i && !fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q];

    assign in_instr.func = in_func_i;
    assign in_instr.rgi  = in_reg_i;
    assign in_instr.addr = in_addr_i;
    assign in_instr.inc  = in_addr_inc_i;
    assign in_instr.sx   = in_stride_x_i;
    assign in_instr.sy   = in_stride_y_i;
    assign in_instr.cnt  = in_count_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + LOGDEPTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + LOGDEPTH'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + (LOGDEPTH+1)'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - (LOGDEPTH+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (!reset_i && push) begin
            fifo_mem_q[wr_ptr_q] <= in_instr;
        end
    end

    // ------------------------------------------------------------------
    // Expansion FSM and output registers
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [2:0]      func_q, func_d;
    logic [4:0]      reg_q, reg_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   inc_q, inc_d;
    logic [SW-1:0]   sx_q, sx_d;
    logic [SW-1:0]   sy_q, sy_d;
    logic [7:0]      rep_q, rep_d;
    logic            hazard;
    logic [2:0]      head_func;

    // The op on the output this cycle is the "last issued" op at the next
    // edge. From IDLE the output is already NOP, so a store seen two cycles
    // back never causes a bubble.
    assign hazard = (func_q == FUNC_STORE) && (head.func == FUNC_LOAD);

    // Invalid codes still consume their repeat slots, but as NOPs.
    assign head_func = ((head.func == FUNC_LOAD) || (head.func == FUNC_STORE) ||
                        (head.func == FUNC_ZERO)) ? head.func : FUNC_NOP;

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        reg_d   = reg_q;
        addr_d  = addr_q;
        inc_d   = inc_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        rep_d   = rep_q;
        pop     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                func_d = FUNC_NOP;
                if (!fifo_empty) begin
                    if (hazard) begin
                        state_d = ST_BUBBLE;
                    end else begin
                        func_d  = head_func;
                        reg_d   = head.rgi;
                        addr_d  = head.addr;
                        inc_d   = head.inc;
                        sx_d    = head.sx;
                        sy_d    = head.sy;
                        rep_d   = head.cnt;
                        pop     = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (rep_q != 8'd0) begin
                    addr_d = addr_q + inc_q;
                    rep_d  = rep_q - 8'd1;
                end else if (!fifo_empty) begin
                    if (hazard) begin
                        func_d  = FUNC_NOP;
                        state_d = ST_BUBBLE;
                    end else begin
                        func_d = head_func;
                        reg_d  = head.rgi;
                        addr_d = head.addr;
                        inc_d  = head.inc;
                        sx_d   = head.sx;
                        sy_d   = head.sy;
                        rep_d  = head.cnt;
                        pop    = 1'b1;
                    end
                end else begin
                    func_d  = FUNC_NOP;
                    state_d = ST_IDLE;
                end
            end

            ST_BUBBLE: begin
                // The head that caused the bubble is still queued.
                func_d  = head_func;
                reg_d   = head.rgi;
                addr_d  = head.addr;
                inc_d   = head.inc;
                sx_d    = head.sx;
                sy_d    = head.sy;
                rep_d   = head.cnt;
                pop     = 1'b1;
                state_d = ST_RUN;
            end

            default: begin
                func_d  = FUNC_NOP;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            func_q  <= FUNC_NOP;
            reg_q   <= '0;
            addr_q  <= '0;
            inc_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            reg_q   <= reg_d;
            addr_q  <= addr_d;
            inc_q   <= inc_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            rep_q   <= rep_d;
        end
    end

    assign risk_func_o     = func_q;
    assign risk_reg_o      = reg_q;
    assign risk_addr_o     = addr_q;
    assign risk_stride_x_o = sx_q;
    assign risk_stride_y_o = sy_q;

    // Any non-IDLE state means either repeats remain, the final op is on the
    // output, or a bubble is pending; busy drops with the trailing NOP.
    assign busy_o = (state_q != ST_IDLE) || !fifo_empty;

`ifdef RISK_ISSUE_PERF_EN
    logic [15:0] perf_issued_q, perf_issued_d;
    logic [15:0] perf_bubbles_q, perf_bubbles_d;
    logic        out_valid_op;

    assign out_valid_op = (func_q == FUNC_LOAD) || (func_q == FUNC_STORE) ||
                          (func_q == FUNC_ZERO);

    always_comb begin
        perf_issued_d  = perf_issued_q;
        perf_bubbles_d = perf_bubbles_q;
        if (out_valid_op && (perf_issued_q != 16'hFFFF)) begin
            perf_issued_d = perf_issued_q + 16'd1;
        end
        if ((state_q == ST_BUBBLE) && (perf_bubbles_q != 16'hFFFF)) begin
            perf_bubbles_d = perf_bubbles_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_issued_q  <= '0;
            perf_bubbles_q <= '0;
        end else begin
            perf_issued_q  <= perf_issued_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign perf_issued_o  = perf_issued_q;
    assign perf_bubbles_o = perf_bubbles_q;
`endif

endmodule

// File: doc/risk_issue.md
Name: risk_issue

Overview:
- Upstream issue stage for the risk matrix unit. Drives its risk_func / risk_reg / risk_addr / risk_stride_x / risk_stride_y inputs.
- Accepts compact matrix instructions through a valid/ready port into a DEPTH-entry FIFO.
- Expands each instruction into count+1 consecutive risk ops with auto-incremented address.
- Inserts a one-cycle bubble on the store-then-load hazard.

Parameters:
- LOGCNT, 5, memory bank count log2; address width = 10+LOGCNT, stride width = 10+LOGCNT-1.
- LOGDEPTH, 2, log2 of instruction FIFO depth (DEPTH = 4).

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  instruction FIFO not full (combinational = !full).
- in_func  in  3  000 load, 001 store, 010 zero; other codes are invalid.
- in_reg  in  5  register index.
- in_addr  in  10+LOGCNT  start address.
- in_addr_inc  in  10+LOGCNT  address increment per repeat.
- in_stride_x  in  10+LOGCNT-1  x stride, held for all repeats.
- in_stride_y  in  10+LOGCNT-1  y stride, held for all repeats.
- in_count  in  8  extra repeats; total ops = in_count+1.
- risk_func  out  3  registered; 3'b111 = NOP.
- risk_reg  out  5  registered.
- risk_addr  out  10+LOGCNT  registered.
- risk_stride_x  out  10+LOGCNT-1  registered.
- risk_stride_y  out  10+LOGCNT-1  registered.
- busy  out  1  FIFO non-empty, or repeats remaining, or bubble pending.

Behaviour:
- Reset (sync): FIFO emptied, repeat counter 0, state IDLE.
  - Outputs after reset: risk_func=3'b111, risk_reg=0, risk_addr=0, strides=0, busy=0.
  - Pushes presented in the reset cycle are dropped.
  - Reset mid-expansion discards the current instruction and all queued instructions.
- Push: an instruction is accepted on any edge with in_valid && in_ready.
  - Invalid in_func codes (011..111) are accepted but the whole instruction issues as NOP cycles (count+1 of them).
- FIFO full/empty:
  - in_ready=0 while full, even when a pop occurs in the same cycle. The pop frees space for the next cycle.
  - Push into an empty FIFO: the entry becomes head after that edge.
- Latency: an instruction accepted at edge k appears on risk_* after edge k+1 at the earliest (FIFO empty, unit idle).
- States:
  - IDLE: outputs NOP. If FIFO non-empty and no hazard → load head into the output registers, rep=count, pop, go to RUN.
  - RUN, rep>0: risk_addr += addr_inc (mod 2^(10+LOGCNT), wraps silently); rep--. func, reg and strides are unchanged.
  - RUN, rep==0, with a next instruction available:
    - No hazard → issue it back-to-back (no gap), pop.
    - Hazard → go to BUBBLE.
  - RUN, rep==0, FIFO empty → outputs NOP, go to IDLE.
  - BUBBLE: outputs NOP for exactly one cycle, then issue the head and pop, go to RUN.
- Hazard definition: the last issued op was a store (001) and the head is a load (000), regardless of register or address.
  - The bubble covers the risk unit's one-cycle-delayed write enable.
  - The hazard is also evaluated from IDLE. IDLE entered directly after a store counts as one cycle of separation, so no extra bubble is needed.
- Simultaneous push and pop on a non-full FIFO: both happen, occupancy unchanged.
- Zero ops (010) still increment the address per repeat.
- busy falls on the edge that outputs the final NOP after the last op.

Optional Feature:
RISK_ISSUE_PERF_EN
- Defined:
  - Adds outputs perf_issued [15:0] and perf_bubbles [15:0], both reset to 0.
  - perf_issued increments on every cycle risk_func is a valid op (000/001/010).
  - perf_bubbles increments on every BUBBLE cycle.
  - Both counters saturate at 16'hFFFF.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset; push zero reg=0 addr=0 count=0 → after 2 edges func=010 for one cycle, then 111; busy high exactly during the queued/issue window.
- Push load reg=1 addr=0x0010 inc=0x0040 count=3 → risk_addr 0x0010,0x0050,0x0090,0x00D0 on consecutive cycles, func=000 throughout, then NOP.
- Push store count=0 then load count=0 back-to-back → func sequence 001, 111, 000; perf_bubbles=1 (with macro).
- Issue load count=20; push 5 more instrs meanwhile → in_ready low after 4 queued, 5th held until the first pop, all 6 issued in order with no gaps.
- Load addr=0x7FF0 inc=0x0020 count=1 → risk_addr 0x7FF0 then 0x0010 (wrap).
- Reset asserted mid-run of count=10 with 2 queued → next cycle func=111, busy=0, later pushes issue normally with no remnants.
